// File: rtl/multi_clk_gen_pkg.sv
// Shared types and helpers for the multi-channel clock/tick generator.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
//
// Holds the config-field format (half-period / phase, ns), the fixed-point
// accumulator width, and the ns-per-clk fixed-point step computation.
package multi_clk_gen_pkg;

  localparam int RESOLUTION = 32;                     // width of ns config fields
  localparam int FRAC       = 16;                     // fractional accumulator bits
  // One extra bit of headroom: acc never exceeds thr + UNIT_FP.
  localparam int ACC_W      = RESOLUTION + FRAC + 1;

  typedef logic [ACC_W-1:0] acc_t;

  typedef struct packed {
    logic [RESOLUTION-1:0] half;   // half-period, ns; 0 = stopped
    logic [RESOLUTION-1:0] phase;  // start offset, ns
  } cfg_t;

  // ns per clk in FRAC fixed point; truncation error is below 2^-FRAC ns.
  function automatic acc_t unit_fp(input longint unsigned second,
                                   input longint unsigned freq);
    longint unsigned num;
    num = second << FRAC;
    return acc_t'(num / freq);
  endfunction

endpackage

// File: rtl/clk_gen_channel.sv
// One generator channel: fixed-point ns accumulator, clk toggle, shadow config slot.
// Latency: registered outputs; first toggle ceil((thr-ph)/UNIT) clk after the enable-edge preload.
// Backpressure: none; a load always lands in the shadow slot, overwriting any older pending value.
//
// Ports: clk/rst_n (sync, active low), load strobe + cfg_in, enable level, sync pulse;
//        clk_out generated clock, tick one-cycle pulse per toggle, pending shadow-valid flag.
module clk_gen_channel
  import multi_clk_gen_pkg::*;
#(
  parameter acc_t UNIT = unit_fp(64'd1000000000, 64'd400000000)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  cfg_t cfg_in,
  input  logic enable,
  input  logic sync,
  output logic clk_out,
  output logic tick,
  output logic pending
);

  acc_t acc_q, acc_d;
  logic clk_q, clk_d;
  logic tick_q, tick_d;
  logic en_q, en_d;
  logic pend_q, pend_d;
  cfg_t act_q, act_d;
  cfg_t shd_q, shd_d;

  acc_t thr, phase_fp, ph, nxt;
  logic apply;

  always_comb begin
    thr      = acc_t'({act_q.half, {FRAC{1'b0}}});
    phase_fp = acc_t'({act_q.phase, {FRAC{1'b0}}});
    nxt      = acc_q + UNIT;
    // Phase is clamped below the threshold so the preload never starts past an edge.
    if (act_q.half == '0)    ph = '0;
    else if (phase_fp < thr) ph = phase_fp;
    else                     ph = thr - acc_t'(1);

    acc_d  = acc_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    en_d   = enable;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    apply  = 1'b0;

    if (!enable) begin
      acc_d = '0;
      clk_d = 1'b0;
      apply = pend_q;
    end else if (sync || !en_q) begin
      // Realign / first enabled cycle: preload the phase, output low, no tick.
      acc_d = ph;
      clk_d = 1'b0;
    end else if (act_q.half == '0) begin
      acc_d = acc_q;
    end else if (thr <= UNIT) begin
      // Half-period shorter than one clk: saturate at clk/2.
      clk_d  = ~clk_q;
      tick_d = 1'b1;
      acc_d  = '0;
      apply  = pend_q;
    end else if (nxt >= thr) begin
      // Remainder is carried so fractional periods do not drift.
      clk_d  = ~clk_q;
      tick_d = 1'b1;
      acc_d  = nxt - thr;
      apply  = pend_q;
    end else begin
      acc_d = nxt;
    end

    // New config only swaps in on an edge (or while idle), so no half-period is cut short.
    if (apply) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
    // A load in the same cycle as an apply becomes the next pending value.
    if (load) begin
      shd_d  = cfg_in;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      en_q   <= 1'b0;
      pend_q <= 1'b0;
      act_q  <= '0;
      shd_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      en_q   <= en_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule

// File: rtl/multi_clk_gen.sv
// Multi-channel programmable clock/tick generator for the correlator timebase.
// Latency: all outputs registered; config takes effect at the next toggle (or at once while disabled).
// Backpressure: none; cfg_load is a fire-and-forget strobe, cfg_ch >= NUM_CH is dropped.
//
// Ports: clk, rst_n (sync, active low); cfg_load/cfg_ch/cfg_half_ns/cfg_phase_ns config write;
//        enable[NUM_CH] run levels; sync realign pulse; clk_out/tick/pending per channel.
module multi_clk_gen
  import multi_clk_gen_pkg::*;
#(
  parameter int                NUM_CH        = 4,
  parameter longint unsigned   CLK_FREQUENCY = 64'd400000000,
  parameter longint unsigned   SECOND        = 64'd1000000000,
  localparam int               CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_load,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [RESOLUTION-1:0] cfg_half_ns,
  input  logic [RESOLUTION-1:0] cfg_phase_ns,
  input  logic [NUM_CH-1:0]     enable,
  input  logic                  sync,
  output logic [NUM_CH-1:0]     clk_out,
  output logic [NUM_CH-1:0]     tick,
  output logic [NUM_CH-1:0]     pending
);

  localparam acc_t UNIT_FP = unit_fp(SECOND, CLK_FREQUENCY);

  cfg_t cfg_in;
  assign cfg_in = '{half: cfg_half_ns, phase: cfg_phase_ns};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ld;
    // Out-of-range channel numbers match no instance and are silently dropped.
    assign ld = cfg_load && (cfg_ch == CH_W'(i));

    clk_gen_channel #(
      .UNIT(UNIT_FP)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (ld),
      .cfg_in  (cfg_in),
      .enable  (enable[i]),
      .sync    (sync),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end

endmodule

// File: tb/tb_multi_clk_gen.sv
// Self-checking bench for multi_clk_gen: expected tick times are queued per channel when
// stimulus is applied and popped as the DUT ticks. A second 3-channel instance shares the
// inputs so an out-of-range cfg_ch (3) can be driven on a 2-bit channel select.
module tb_multi_clk_gen;
  import multi_clk_gen_pkg::*;

  localparam int NCH = 4;

  typedef struct {
    int cyc;
    bit lvl;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cfg_load = 1'b0;
  logic [1:0]            cfg_ch = '0;
  logic [RESOLUTION-1:0] cfg_half_ns = '0;
  logic [RESOLUTION-1:0] cfg_phase_ns = '0;
  logic [NCH-1:0]        enable = '0;
  logic                  sync = 1'b0;
  logic [NCH-1:0]        clk_out, tick, pending;
  logic [2:0]            clk_out3, tick3, pending3;

  multi_clk_gen #(.NUM_CH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_ch(cfg_ch),
    .cfg_half_ns(cfg_half_ns), .cfg_phase_ns(cfg_phase_ns), .enable(enable),
    .sync(sync), .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  multi_clk_gen #(.NUM_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_ch(cfg_ch),
    .cfg_half_ns(cfg_half_ns), .cfg_phase_ns(cfg_phase_ns), .enable(enable[2:0]),
    .sync(sync), .clk_out(clk_out3), .tick(tick3), .pending(pending3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[NCH][$];
  bit   lvl_exp[NCH];
  int   tick_cnt[NCH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push_tick(input int c, input int at);
    exp_t e;
    lvl_exp[c] = ~lvl_exp[c];
    e.cyc = at;
    e.lvl = lvl_exp[c];
    exp_q[c].push_back(e);
  endtask

  // Every observed tick must match the head of its channel's queue in time and level.
  task automatic monitor();
    exp_t e;
    for (int c = 0; c < NCH; c++) begin
      if (tick[c] === 1'b1) begin
        tick_cnt[c]++;
        if (exp_q[c].size() == 0) begin
          check($sformatf("unexpected_tick_ch%0d", c), 64'(tick[c]), 64'd0);
        end else begin
          e = exp_q[c].pop_front();
          check($sformatf("tick_cyc_ch%0d", c), 64'(cyc), 64'(e.cyc));
          check($sformatf("tick_lvl_ch%0d", c), 64'(clk_out[c]), 64'(e.lvl));
        end
      end
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    monitor();
  endtask

  task automatic run_until(input int c);
    while (cyc < c) nxt();
  endtask

  task automatic drain(input int c);
    check($sformatf("missed_ticks_ch%0d", c), 64'(exp_q[c].size()), 64'd0);
    exp_q[c].delete();
  endtask

  task automatic load(input int c, input int half, input int phase);
    cfg_load     = 1'b1;
    cfg_ch       = 2'(c);
    cfg_half_ns  = RESOLUTION'(half);
    cfg_phase_ns = RESOLUTION'(phase);
    nxt();
    cfg_load = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: cyc %0d reached time limit", cyc);
    $fatal(1);
  end

  initial begin
    int e, s, t;
    int iv[5];
    iv = '{3, 2, 3, 2, 2};

    // Reset held with all channels enabled: everything stays low.
    rst_n  = 1'b0;
    enable = '1;
    repeat (3) begin
      nxt();
      check("rst_clk_out", 64'(clk_out), 64'd0);
      check("rst_tick", 64'(tick), 64'd0);
      check("rst_pending", 64'(pending), 64'd0);
    end
    enable = '0;
    rst_n  = 1'b1;
    nxt();

    // Integer period: half=10ns at 2.5ns/clk -> toggle every 4 clk.
    load(0, 10, 0);
    check("pend_set_ch0", 64'(pending[0]), 64'd1);
    nxt();
    check("pend_apply_idle_ch0", 64'(pending[0]), 64'd0);
    enable[0] = 1'b1;
    e = cyc + 1;
    for (int k = 0; k < 8; k++) push_tick(0, e + 4 + 4 * k);
    run_until(e + 32);
    drain(0);

    // Reconfigure mid half-period: old half completes, then 2-clk halves.
    t = cyc;
    nxt();
    load(0, 5, 0);
    check("reconf_pend_ch0", 64'(pending[0]), 64'd1);
    push_tick(0, t + 4);
    for (int k = 0; k < 4; k++) push_tick(0, t + 6 + 2 * k);
    nxt();
    check("reconf_pend_hold_ch0", 64'(pending[0]), 64'd1);
    nxt();
    check("reconf_pend_clr_ch0", 64'(pending[0]), 64'd0);
    run_until(t + 12);
    enable[0] = 1'b0;
    nxt();
    check("disable_clk_ch0", 64'(clk_out[0]), 64'd0);
    check("disable_tick_ch0", 64'(tick[0]), 64'd0);
    drain(0);

    // Fractional period: half=6ns -> intervals 3,2,3,2,2; 500 toggles in 1200 clk.
    load(1, 6, 0);
    nxt();
    tick_cnt[1] = 0;
    enable[1] = 1'b1;
    e = cyc + 1;
    t = e;
    for (int p = 0; p < 100; p++) begin
      for (int k = 0; k < 5; k++) begin
        t += iv[k];
        push_tick(1, t);
      end
    end
    run_until(e + 1200);
    enable[1] = 1'b0;
    check("frac_toggles_ch1", 64'(tick_cnt[1]), 64'd500);
    drain(1);

    // Phase preload and sync realignment.
    load(2, 10, 5);
    load(3, 10, 0);
    nxt();
    enable[3:2] = 2'b11;
    e = cyc + 1;
    push_tick(2, e + 2);
    push_tick(2, e + 6);
    push_tick(2, e + 10);
    push_tick(3, e + 4);
    push_tick(3, e + 8);
    run_until(e + 10);
    sync = 1'b1;
    s = cyc + 1;
    nxt();
    sync = 1'b0;
    check("sync_clk_ch2", 64'(clk_out[2]), 64'd0);
    check("sync_clk_ch3", 64'(clk_out[3]), 64'd0);
    check("sync_tick_ch23", 64'(tick[3:2]), 64'd0);
    lvl_exp[2] = 1'b0;
    lvl_exp[3] = 1'b0;
    for (int k = 0; k < 4; k++) push_tick(2, s + 2 + 4 * k);
    for (int k = 0; k < 3; k++) push_tick(3, s + 4 + 4 * k);
    run_until(s + 14);
    enable[3:2] = 2'b00;
    nxt();
    drain(2);
    drain(3);

    // half=0: enabled but stopped.
    load(0, 0, 0);
    nxt();
    enable[0] = 1'b1;
    repeat (20) nxt();
    check("stopped_clk_ch0", 64'(clk_out[0]), 64'd0);
    drain(0);

    // half=1ns (< one clk): toggles every clk.
    enable[0] = 1'b0;
    load(0, 1, 0);
    nxt();
    enable[0]  = 1'b1;
    lvl_exp[0] = 1'b0;
    e = cyc + 1;
    for (int k = 1; k <= 10; k++) push_tick(0, e + k);
    run_until(e + 10);
    enable[0] = 1'b0;
    nxt();
    drain(0);

    // Out-of-range cfg_ch on the 3-channel instance changes nothing.
    load(0, 0, 0);
    load(1, 0, 0);
    load(2, 0, 0);
    nxt();
    load(3, 10, 0);
    check("oor_pend_ref", 64'(pending[3]), 64'd1);
    check("oor_pend_dut3", 64'(pending3), 64'd0);
    enable = 4'b0111;
    repeat (10) nxt();
    check("oor_tick_dut3", 64'(tick3), 64'd0);
    check("oor_clk_dut3", 64'(clk_out3), 64'd0);
    check("oor_pend_dut3_late", 64'(pending3), 64'd0);
    enable = '0;
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
